chan_buffer: RTL and testbench

Multi-channel, valid-gated delay buffer: each accepted beat carries CH parallel words and reappears at the output exactly N accepted beats later. N is selectable at run time up to DEPTH. Successor to the single-channel fixed-depth `buffer`, adding channel count, run-time depth and an optional flush/drain mode. Sits between HOG pipeline stages wherever cell or row data must be realigned by a beat count.

---
 rtl/buffer_pkg.sv | 27 ++
 rtl/buffer_mem.sv | 28 ++
 rtl/chan_buffer.sv | 147 ++++++++++++++
 tb/tb_chan_buffer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | buffer_pkg : shared types and helpers for the chan_buffer delay line       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  // Zero delay is meaningless, so it is promoted to one beat.
  function automatic int unsigned clamp_depth(input int unsigned d, input int unsigned max_d);
    if (d == 0) return 1;
    if (d > max_d) return max_d;
    return d;
  endfunction

  function automatic int unsigned chan_lsb(input int unsigned c, input int unsigned w);
    return c * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/buffer_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | buffer_mem : DEPTH x W storage, one write port, combinational read port    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module buffer_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/chan_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chan_buffer : multi-channel valid-gated delay line, run-time depth N        |
// | Optional drain mode enabled by defining BUFFER_FLUSH_EN                     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module chan_buffer
  import buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CH     = 1,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH*DATA_W-1:0] i_data,
  input  logic                 i_valid,
  input  logic                 clear,
  input  logic [CNT_W-1:0]     i_depth,
  input  logic                 i_flush,
  output logic [CH*DATA_W-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W     = CH * DATA_W;

  function automatic logic [PTR_W-1:0] ptr_sub(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] k);
    int unsigned t;
    t = 32'(p) + 32'(DEPTH) - 32'(k);
    if (t >= 32'(DEPTH)) t = t - 32'(DEPTH);
    return PTR_W'(t);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == 32'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, cnt_q, cnt_d, rem_q, rem_d, n_load;
  logic [PTR_W-1:0] wptr_q, wptr_d, dptr_q, dptr_d, raddr;
  logic [W-1:0]     o_data_q, o_data_d, rd_data;
  logic             o_valid_q, o_valid_d, o_busy_q, o_busy_d;
  logic             we, flush_go;

  assign n_load = CNT_W'(clamp_depth(32'(i_depth), DEPTH));

`ifdef BUFFER_FLUSH_EN
  assign flush_go = i_flush && (cnt_q != '0);
`else
  logic unused_flush;
  assign unused_flush = i_flush;
  assign flush_go     = 1'b0;
`endif

  buffer_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (we),
    .i_waddr (wptr_q),
    .i_wdata (i_data),
    .i_raddr (raddr),
    .o_rdata (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    wptr_d    = wptr_q;
    dptr_d    = dptr_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    o_busy_d  = 1'b0;
    we        = 1'b0;
    raddr     = ptr_sub(wptr_q, n_q);

    if (rst || clear) begin
      n_d     = n_load;
      state_d = ST_IDLE;
      cnt_d   = '0;
      rem_d   = '0;
      wptr_d  = '0;
      dptr_d  = '0;
      if (rst) o_data_d = '0;
    end else if (state_q == ST_DRAIN) begin
      raddr = dptr_q;
      if (rem_q != '0) begin
        o_data_d  = rd_data;
        o_valid_d = 1'b1;
        o_busy_d  = 1'b1;
        dptr_d    = ptr_inc(dptr_q);
        rem_d     = rem_q - 1'b1;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (flush_go) begin
      // The oldest stored beat leaves in the flush cycle itself.
      raddr     = ptr_sub(wptr_q, cnt_q);
      o_data_d  = rd_data;
      o_valid_d = 1'b1;
      o_busy_d  = 1'b1;
      dptr_d    = ptr_inc(raddr);
      rem_d     = cnt_q - 1'b1;
      state_d   = ST_DRAIN;
    end else if (i_valid) begin
      we     = 1'b1;
      wptr_d = ptr_inc(wptr_q);
      if (cnt_q == n_q) begin
        o_data_d  = rd_data;
        o_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      state_d = (cnt_d == n_q) ? ST_STREAM : ST_FILL;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    n_q       <= n_d;
    cnt_q     <= cnt_d;
    rem_q     <= rem_d;
    wptr_q    <= wptr_d;
    dptr_q    <= dptr_d;
    o_data_q  <= o_data_d;
    o_valid_q <= o_valid_d;
    o_busy_q  <= o_busy_d;
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    assign o_data[chan_lsb(c, DATA_W) +: DATA_W] = o_data_q[chan_lsb(c, DATA_W) +: DATA_W];
  end

  assign o_valid = o_valid_q;
  assign o_busy  = o_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_chan_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_chan_buffer : directed self-checking bench for chan_buffer               |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_chan_buffer;

  localparam int DATA_W = 16;
  localparam int CH     = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int W      = CH * DATA_W;

  logic             clk = 1'b0;
  logic             rst, i_valid, clear, i_flush;
  logic [W-1:0]     i_data, o_data;
  logic [CNT_W-1:0] i_depth;
  logic             o_valid, o_busy;

  int          checks   = 0;
  int          failures = 0;
  logic [W-1:0] last_data;

  chan_buffer #(
    .DATA_W (DATA_W),
    .CH     (CH),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .clear   (clear),
    .i_depth (i_depth),
    .i_flush (i_flush),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  // Beat k carries 100*k + c on channel c.
  function automatic logic [W-1:0] beat(input int k);
    logic [W-1:0] b;
    for (int c = 0; c < CH; c++) b[c*DATA_W +: DATA_W] = DATA_W'(100 * k + c);
    return b;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input int d, input logic with_beat);
    i_depth = CNT_W'(d);
    clear   = 1'b1;
    i_valid = with_beat;
    i_data  = beat(777);
    tick();
    clear   = 1'b0;
    i_valid = 1'b0;
    check("clear_valid", W'(o_valid), W'(0));
  endtask

  task automatic run_stream(input int n, input int base, input int count);
    for (int k = 0; k < count; k++) begin
      i_valid = 1'b1;
      i_data  = beat(base + k);
      tick();
      check("strm_valid", W'(o_valid), W'(k >= n));
      check("strm_busy", W'(o_busy), W'(0));
      if (k >= n) begin
        check("strm_data", o_data, beat(base + k - n));
        last_data = beat(base + k - n);
      end
    end
    i_valid = 1'b0;
  endtask

  initial begin
    int acc;
    rst = 1'b1; clear = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
    i_depth = CNT_W'(3); i_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_data", o_data, '0);
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_busy", W'(o_busy), W'(0));

    // N=3 latched at reset, then N=5 with four-channel pattern
    run_stream(3, 0, 8);
    do_clear(5, 1'b0);
    run_stream(5, 10, 12);

    // N=3 with gaps: outputs only on accepted cycles, data held otherwise
    do_clear(3, 1'b0);
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      i_valid = (i % 2 == 0);
      i_data  = beat(50 + acc);
      tick();
      if (i % 2 == 0) begin
        check("gap_valid", W'(o_valid), W'(acc >= 3));
        if (acc >= 3) begin
          check("gap_data", o_data, beat(50 + acc - 3));
          last_data = beat(50 + acc - 3);
        end
        acc++;
      end else begin
        check("gap_idle_valid", W'(o_valid), W'(0));
        check("gap_hold", o_data, last_data);
      end
    end
    i_valid = 1'b0;

    // Depth clamp: 0 -> 1, DEPTH+7 -> DEPTH, across wrap-around
    do_clear(0, 1'b0);
    run_stream(1, 100, 6);
    do_clear(DEPTH + 7, 1'b0);
    run_stream(DEPTH, 120, 3 * DEPTH);

    // Beat presented with clear is dropped
    do_clear(4, 1'b0);
    run_stream(4, 200, 6);
    do_clear(4, 1'b1);
    run_stream(4, 300, 5);

    // Flush with N=8 after five beats
    do_clear(8, 1'b0);
    run_stream(8, 400, 5);
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_data  = beat(999);
`ifdef BUFFER_FLUSH_EN
    for (int j = 0; j < 5; j++) begin
      tick();
      i_flush = 1'b0;
      check("drain_valid", W'(o_valid), W'(1));
      check("drain_busy", W'(o_busy), W'(1));
      check("drain_data", o_data, beat(400 + j));
    end
    tick();
    i_valid = 1'b0;
    check("drain_end_busy", W'(o_busy), W'(0));
    check("drain_end_valid", W'(o_valid), W'(0));
`else
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check("noflush_valid", W'(o_valid), W'(0));
      check("noflush_busy", W'(o_busy), W'(0));
      tick();
    end
    do_clear(8, 1'b0);
`endif
    run_stream(8, 500, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
